vga_timing_generator: RTL

Parametrised VGA raster timing generator and pixel output stage, the successor to the fixed 800x600@60 Hz (1056x628 total) basic controller. It generates horizontal/vertical counters with programmable porch, sync and polarity values. It exports pixel coordinates to the upstream pixel source and re-aligns that source's colour to the syncs through a configurable pipeline latency. It drives the VGA connector directly and offers a clock enable, so it can run from a system clock faster than the pixel clock.

---
 rtl/vga_timing_generator.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/vga_timing_generator.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_generator
//  Purpose  : Parametrised VGA raster timing generator with pixel output
//             stage. Produces horizontal/vertical scan counters, exports the
//             current coordinate to an upstream pixel source, and re-aligns
//             that source's colour to the syncs through a PIPE_LAT-deep
//             delay line before registering the DAC/sync outputs.
//  Ports    : clk         - system clock, rising edge
//             rst_n       - asynchronous active-low reset
//             pix_en      - pixel tick; all state advances only when high
//             color       - colour for the coordinate shown PIPE_LAT ticks ago
//             x, y        - current horizontal / vertical count
//             active      - current coordinate lies in the visible area
//             line_start  - x == 0 on a pixel tick
//             frame_start - x == 0, y == 0 on a pixel tick
//             rgb         - colour to DAC, zero outside the visible area
//             hsync,vsync - sync outputs with programmable polarity
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_generator #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FRONT   = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BACK    = 88,
  parameter int unsigned V_ACTIVE  = 600,
  parameter int unsigned V_FRONT   = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BACK    = 23,
  parameter bit          HSYNC_POL = 1'b1,
  parameter bit          VSYNC_POL = 1'b1,
  parameter int unsigned COLOR_W   = 3,
  parameter int unsigned PIPE_LAT  = 2,
  parameter int unsigned H_W       = 11,
  parameter int unsigned V_W       = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  input  logic [COLOR_W-1:0] color,
  output logic [H_W-1:0]     x,
  output logic [V_W-1:0]     y,
  output logic               active,
  output logic               line_start,
  output logic               frame_start,
  output logic [COLOR_W-1:0] rgb,
  output logic               hsync,
  output logic               vsync
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_BEGIN   = H_W'(H_ACTIVE + H_FRONT);
  localparam logic [H_W-1:0] HS_END     = H_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_BEGIN   = V_W'(V_ACTIVE + V_FRONT);
  localparam logic [V_W-1:0] VS_END     = V_W'(V_ACTIVE + V_FRONT + V_SYNC);

  // --------------------------------------------------------------------------
  // Scan counters
  // --------------------------------------------------------------------------
  logic [H_W-1:0] cnt_h_q, cnt_h_d;
  logic [V_W-1:0] cnt_v_q, cnt_v_d;

  always_comb begin
    cnt_h_d = cnt_h_q;
    cnt_v_d = cnt_v_q;
    if (pix_en) begin
      if (cnt_h_q == H_LAST) begin
        cnt_h_d = '0;
        cnt_v_d = (cnt_v_q == V_LAST) ? '0 : cnt_v_q + V_W'(1);
      end else begin
        cnt_h_d = cnt_h_q + H_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_h_q <= '0;
      cnt_v_q <= '0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end

  // --------------------------------------------------------------------------
  // Combinational region decode (zero latency relative to the counters)
  // --------------------------------------------------------------------------
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] dec_now;   // {active, hs_raw, vs_raw} for the current coordinate
  logic [2:0] dec_del;   // same bundle, PIPE_LAT ticks old

  assign active      = (cnt_h_q < H_ACT_END) && (cnt_v_q < V_ACT_END);
  assign hs_raw      = (cnt_h_q >= HS_BEGIN) && (cnt_h_q < HS_END);
  assign vs_raw      = (cnt_v_q >= VS_BEGIN) && (cnt_v_q < VS_END);
  assign dec_now     = {active, hs_raw, vs_raw};

  assign x           = cnt_h_q;
  assign y           = cnt_v_q;
  assign line_start  = pix_en && (cnt_h_q == '0);
  assign frame_start = line_start && (cnt_v_q == '0);

  // --------------------------------------------------------------------------
  // Delay line: matches the decode to the upstream pixel source latency so
  // that the colour arriving now belongs to the decode being retired now.
  // --------------------------------------------------------------------------
  if (PIPE_LAT > 0) begin : g_pipe
    logic [3*PIPE_LAT-1:0] pipe_q, pipe_d;
    logic [3*PIPE_LAT+2:0] pipe_shift;

    // Newest entry enters at the bottom; the top 3 bits of the shifted
    // vector are the oldest entry, i.e. the one leaving the line.
    always_comb begin
      pipe_shift = {pipe_q, dec_now};
      pipe_d     = pix_en ? pipe_shift[3*PIPE_LAT-1:0] : pipe_q;
    end

    assign dec_del = pipe_shift[3*PIPE_LAT+2 -: 3];

    // Cleared to inactive/no-sync so nothing stale leaks after a reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end
  end else begin : g_no_pipe
    assign dec_del = dec_now;
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;

  always_comb begin
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_en) begin
      rgb_d   = dec_del[2] ? color : '0;
      // XNOR with the polarity: asserted level equals the POL bit.
      hsync_d = ~(dec_del[1] ^ HSYNC_POL);
      vsync_d = ~(dec_del[0] ^ VSYNC_POL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q   <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign rgb   = rgb_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule
`default_nettype wire
